// File: rtl/multicycle_control_fsm.sv
// Main control FSM and ALU decoder for the multicycle MIPS datapath.
// Optional jump support is enabled by defining MC_CTRL_JUMP_EN.
module multicycle_control_fsm #(
    parameter int                OP_W     = 6,
    parameter int                ALUC_W   = 3,
    parameter int                CNT_W    = 32,
    parameter logic [OP_W-1:0]   OP_RTYPE = 6'h00,
    parameter logic [OP_W-1:0]   OP_LW    = 6'h23,
    parameter logic [OP_W-1:0]   OP_SW    = 6'h2B,
    parameter logic [OP_W-1:0]   OP_BEQ   = 6'h04,
    parameter logic [OP_W-1:0]   OP_ADDI  = 6'h08,
    parameter logic [OP_W-1:0]   OP_J     = 6'h02
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [OP_W-1:0]   Function,
    input  logic              MemReady,
    output logic [1:0]        ALUOp,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              IorD,
    output logic [1:0]        PcSrc,
    output logic              RegDes,
    output logic              MemToReg,
    output logic              IRWrite,
    output logic              PcWrite,
    output logic              Branch,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              Illegal,
    output logic [3:0]        State,
    output logic [CNT_W-1:0]  InstrCount
);

    localparam logic [OP_W-1:0] FN_ADD = OP_W'('h20);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'('h22);
    localparam logic [OP_W-1:0] FN_AND = OP_W'('h24);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'('h25);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'('h2A);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
`ifdef MC_CTRL_JUMP_EN
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`else
        S_ADDIWB = 4'd10
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               funct_legal;
    logic               illegal_op;

    always_comb begin
        funct_legal = (Function == FN_ADD) || (Function == FN_SUB) || (Function == FN_AND) ||
                      (Function == FN_OR)  || (Function == FN_SLT);
    end

    // Next state; count advances only when a completing state hands back to FETCH.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if ((OpCode == OP_LW) || (OpCode == OP_SW))        state_d = S_MEMADR;
                else if ((OpCode == OP_RTYPE) && funct_legal)      state_d = S_EXEC;
                else if (OpCode == OP_BEQ)                         state_d = S_BRANCH;
                else if (OpCode == OP_ADDI)                        state_d = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
                else if (OpCode == OP_J)                           state_d = S_JUMP;
`else
                else if (OpCode == OP_J) begin
                    state_d    = S_FETCH;
                    illegal_op = 1'b1;
                end
`endif
                else begin
                    state_d    = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWR: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_CTRL_JUMP_EN
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
`else
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: begin
`endif
                state_d = S_FETCH;
                count_d = count_q + CNT_W'(1);
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore decode; enables and Illegal are suppressed for the whole reset window.
    always_comb begin
        ALUOp    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        IorD     = 1'b0;
        PcSrc    = 2'b00;
        RegDes   = 1'b0;
        MemToReg = 1'b0;
        IRWrite  = 1'b0;
        PcWrite  = 1'b0;
        Branch   = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PcWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = illegal_op;
            end
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMRD:  IorD = 1'b1;
            S_MEMWB:  begin MemToReg = 1'b1; RegWrite = 1'b1; end
            S_MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; end
            S_EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_ALUWB:  begin RegDes = 1'b1; RegWrite = 1'b1; end
            S_BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PcSrc = 2'b01; Branch = 1'b1; end
            S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_ADDIWB: RegWrite = 1'b1;
`ifdef MC_CTRL_JUMP_EN
            S_JUMP:   begin PcSrc = 2'b10; PcWrite = 1'b1; end
`endif
            default:  ;
        endcase
`ifndef MC_CTRL_JUMP_EN
        PcSrc[1] = 1'b0;
`endif
        if (!reset_n) begin
            IRWrite  = 1'b0;
            PcWrite  = 1'b0;
            Branch   = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

    always_comb begin
        case (ALUOp)
            2'b01:   ALUControl = ALUC_W'(3'b110);
            2'b10: begin
                case (Function)
                    FN_ADD:  ALUControl = ALUC_W'(3'b010);
                    FN_SUB:  ALUControl = ALUC_W'(3'b110);
                    FN_AND:  ALUControl = ALUC_W'(3'b000);
                    FN_OR:   ALUControl = ALUC_W'(3'b001);
                    FN_SLT:  ALUControl = ALUC_W'(3'b111);
                    default: ALUControl = ALUC_W'(3'b010);
                endcase
            end
            default: ALUControl = ALUC_W'(3'b010);
        endcase
    end

    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an instruction-level reference model.
// Narrow counter (4 bits) so that wrap-around is reached in a short run.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [5:0]       OpCode, Function;
    logic             MemReady;
    logic [1:0]       ALUOp, ALUSrcB, PcSrc;
    logic [2:0]       ALUControl;
    logic             ALUSrcA, IorD, RegDes, MemToReg;
    logic             IRWrite, PcWrite, Branch, MemWrite, RegWrite, Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .OpCode(OpCode), .Function(Function),
        .MemReady(MemReady), .ALUOp(ALUOp), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .IorD(IorD), .PcSrc(PcSrc), .RegDes(RegDes), .MemToReg(MemToReg),
        .IRWrite(IRWrite), .PcWrite(PcWrite), .Branch(Branch), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
    );

    always #5 clock = ~clock;

    logic [18:0] ctrl_obs;
    assign ctrl_obs = {ALUControl, ALUOp, ALUSrcA, ALUSrcB, IorD, PcSrc, RegDes, MemToReg,
                       IRWrite, PcWrite, Branch, MemWrite, RegWrite, Illegal};

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit funct_ok(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    // Expected control word for a state, from the per-state output table.
    function automatic logic [31:0] exp_ctrl(input int s, input bit mr, input bit ill,
                                             input logic [5:0] fn, input bit rl);
        logic [2:0] ac;
        logic [1:0] aop, sb, ps;
        logic       sa, iord, rd, m2r, irw, pcw, br, mw, rw, il;
        aop  = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
        sa   = (s == 2 || s == 6 || s == 8 || s == 9);
        sb   = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s == 2 || s == 9) ? 2'd2 : 2'd0;
        iord = (s == 3 || s == 5);
        ps   = (s == 8) ? 2'd1 : (s == 11) ? 2'd2 : 2'd0;
        rd   = (s == 7);
        m2r  = (s == 4);
        irw  = (s == 0) && mr;
        pcw  = ((s == 0) && mr) || (s == 11);
        br   = (s == 8);
        mw   = (s == 5);
        rw   = (s == 4 || s == 7 || s == 10);
        il   = (s == 1) && ill;
        if (rl) begin
            irw = 0; pcw = 0; br = 0; mw = 0; rw = 0; il = 0;
        end
        if (aop == 2'd1) ac = 3'b110;
        else if (aop == 2'd2) begin
            case (fn)
                6'h20: ac = 3'b010;
                6'h22: ac = 3'b110;
                6'h24: ac = 3'b000;
                6'h25: ac = 3'b001;
                6'h2A: ac = 3'b111;
                default: ac = 3'b010;
            endcase
        end else ac = 3'b010;
        return {13'b0, ac, aop, sa, sb, iord, ps, rd, m2r, irw, pcw, br, mw, rw, il};
    endfunction

    task automatic step(input int s, input bit mr, input bit rn, input bit ill, input string tag);
        @(negedge clock);
        MemReady = mr;
        reset_n  = rn;
        #1;
        check_val({tag, ".state"}, 32'(State), 32'(s));
        check_val({tag, ".ctrl"}, 32'(ctrl_obs), exp_ctrl(s, mr, ill, Function, !rn));
        check_val({tag, ".cnt"}, 32'(InstrCount), 32'(exp_count));
        @(posedge clock);
    endtask

    // Walks one instruction; waits<0 picks random wait states for FETCH/MEMRD/MEMWR.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits, input string tag);
        int plan[$];
        bit ill;
        int w;
        #1;
        OpCode   = op;
        Function = fn;
        ill      = 1'b0;
        plan     = {0, 1};
        case (op)
            LW:   plan = {plan, 2, 3, 4};
            SW:   plan = {plan, 2, 5};
            RT:   if (funct_ok(fn)) plan = {plan, 6, 7}; else ill = 1'b1;
            BEQ:  plan.push_back(8);
            ADDI: plan = {plan, 9, 10};
`ifdef MC_CTRL_JUMP_EN
            JMP:  plan.push_back(11);
`endif
            default: ill = 1'b1;
        endcase
        foreach (plan[i]) begin
            if (plan[i] == 0 || plan[i] == 3 || plan[i] == 5) begin
                w = (waits >= 0) ? waits : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
                for (int k = 0; k < w; k++) step(plan[i], 1'b0, 1'b1, ill, tag);
                step(plan[i], 1'b1, 1'b1, ill, tag);
            end else begin
                step(plan[i], 1'($urandom_range(0, 1)), 1'b1, ill, tag);
            end
        end
        if (!ill) exp_count = (exp_count + 1) % (1 << CNT_W);
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [5:0] legal_fn [5];
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        reset_n  = 1'b0;
        MemReady = 1'b1;
        OpCode   = LW;
        Function = 6'h20;
        @(posedge clock);
        step(0, 1'b1, 1'b0, 1'b0, "rst0");
        step(0, 1'b1, 1'b0, 1'b0, "rst1");

        run_instr(LW, 6'h20, 2, "lw_wait");
        run_instr(RT, 6'h2A, 0, "r_slt");
        run_instr(RT, 6'h3F, 0, "r_badfn");
        run_instr(BEQ, 6'h00, 0, "beq");
        run_instr(SW, 6'h00, 1, "sw_wait");
        run_instr(6'h3F, 6'h00, 0, "bad_op");
        run_instr(JMP, 6'h00, 0, "jump");
        run_instr(ADDI, 6'h00, 0, "addi");

        // Reset arriving while a store is waiting on memory.
        #1;
        OpCode = SW;
        step(0, 1'b1, 1'b1, 1'b0, "rstwr");
        step(1, 1'b1, 1'b1, 1'b0, "rstwr");
        step(2, 1'b1, 1'b1, 1'b0, "rstwr");
        step(5, 1'b0, 1'b0, 1'b0, "rstwr");
        exp_count = 0;
        step(0, 1'b0, 1'b1, 1'b0, "rstwr_after");
        step(0, 1'b1, 1'b1, 1'b0, "rstwr_after");
        step(1, 1'b1, 1'b1, 1'b0, "rstwr_after");
        step(2, 1'b1, 1'b1, 1'b0, "rstwr_after");
        step(5, 1'b1, 1'b1, 1'b0, "rstwr_after");
        exp_count = 1;

        for (int n = 0; n < 80; n++) begin
            fn = legal_fn[$urandom_range(0, 4)];
            case ($urandom_range(0, 7))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: begin
                    op = RT;
                    do fn = 6'($urandom_range(0, 63)); while (funct_ok(fn));
                end
                4: op = BEQ;
                5: op = ADDI;
                6: op = JMP;
                default: begin
                    do op = 6'($urandom_range(0, 63));
                    while (op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP);
                end
            endcase
            run_instr(op, fn, -1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
